// File: rtl/tpu_mem_pkg.sv
// tpu_mem_pkg: shared types and address-check helpers for the scratchpad responder.
package tpu_mem_pkg;
   typedef enum logic {SRC_CORE, SRC_HOST} src_t;
   typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_RANGE} err_cause_t;
   function automatic int bpw(input int data_width);
      return data_width / 8;
   endfunction
   function automatic err_cause_t err_cause(input logic [31:0] addr, input int bytes, input int words, input int depth);
      if (addr % bytes != 0) return ERR_MISALIGN;
      if (addr / bytes + words > depth) return ERR_RANGE;
      return ERR_NONE;
   endfunction
endpackage

// File: rtl/mem_latency_pipe.sv
// mem_latency_pipe: valid/tag/data delay line; STAGES=0 is a pass-through.
module mem_latency_pipe
   import tpu_mem_pkg::*;
#(
   parameter int STAGES = 0,
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  src_t             in_tag,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output src_t             out_tag,
   output logic [WIDTH-1:0] out_data
);
   if (STAGES == 0) begin : g_wire
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign out_valid = in_valid;
      assign out_tag = in_tag;
      assign out_data = in_data;
   end else begin : g_regs
      logic v [STAGES];
      src_t t [STAGES];
      logic [WIDTH-1:0] d [STAGES];
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
               v[i] <= 1'b0;
               t[i] <= SRC_CORE;
               d[i] <= '0;
            end
         end else begin
            v[0] <= in_valid;
            t[0] <= in_tag;
            d[0] <= in_data;
            for (int i = 1; i < STAGES; i++) begin
               v[i] <= v[i-1];
               t[i] <= t[i-1];
               d[i] <= d[i-1];
            end
         end
      assign out_valid = v[STAGES-1];
      assign out_tag = t[STAGES-1];
      assign out_data = d[STAGES-1];
   end
endmodule

// File: rtl/scratchpad_responder.sv
// scratchpad_responder: fixed-latency banked FP32 scratchpad serving a core beat port
// and a lower-priority single-word host port.
module scratchpad_responder
   import tpu_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BANKING_FACTOR = 1,
   parameter int ADDRESS_WIDTH = 13,
   parameter int DEPTH = 1024,
   parameter int MEM_LATENCY = 2
)(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
   input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
   input  logic                                 mem_read_en,
   input  logic                                 mem_write_en,
   output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
   output logic                                 mem_resp_valid,
   input  logic                                 host_req,
   input  logic                                 host_we,
   input  logic [ADDRESS_WIDTH-1:0]             host_addr,
   input  logic [DATA_WIDTH-1:0]                host_wdata,
   output logic                                 host_gnt,
   output logic [DATA_WIDTH-1:0]                host_rdata,
   output logic                                 host_rvalid,
   output logic                                 err
);
   localparam int BPW = bpw(DATA_WIDTH);
   localparam int BW = BANKING_FACTOR * DATA_WIDTH;
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [31:0] c_word, h_word;
   logic c_ok, h_ok, c_rd, h_rd, new_err, s_valid, p_valid;
   logic [BW-1:0] rd_data, s_data, p_data;
   src_t s_tag, p_tag;

   assign c_word = 32'(mem_req_addr) / BPW;
   assign h_word = 32'(host_addr) / BPW;
   assign c_ok = err_cause(32'(mem_req_addr), BPW, BANKING_FACTOR, DEPTH) == ERR_NONE;
   assign h_ok = err_cause(32'(host_addr), BPW, 1, DEPTH) == ERR_NONE;
   assign host_gnt = host_req & ~mem_read_en & ~mem_write_en;
   assign c_rd = mem_read_en & ~mem_write_en;
   assign h_rd = host_gnt & ~host_we;
   assign new_err = (mem_read_en & mem_write_en) | ((mem_read_en | mem_write_en) & ~c_ok) | (host_gnt & ~h_ok);

   // host only reaches the array when the core port is idle, so the two writers never collide
   always_ff @(posedge clk) begin
      if (mem_write_en && c_ok)
         for (int b = 0; b < BANKING_FACTOR; b++)
            mem[IW'(c_word + 32'(b))] <= mem_req_data[b*DATA_WIDTH +: DATA_WIDTH];
      if (host_gnt && host_we && h_ok)
         mem[IW'(h_word)] <= host_wdata;
   end

   always_comb begin
      rd_data = '0;
      if (c_rd && c_ok)
         for (int b = 0; b < BANKING_FACTOR; b++)
            rd_data[b*DATA_WIDTH +: DATA_WIDTH] = mem[IW'(c_word + 32'(b))];
      else if (h_rd && h_ok)
         rd_data[DATA_WIDTH-1:0] = mem[IW'(h_word)];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s_valid <= 1'b0;
         s_tag <= SRC_CORE;
         s_data <= '0;
      end else begin
         s_valid <= c_rd | h_rd;
         s_tag <= c_rd ? SRC_CORE : SRC_HOST;
         s_data <= rd_data;
      end

   mem_latency_pipe #(.STAGES(MEM_LATENCY - 2), .WIDTH(BW)) u_pipe (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_valid), .in_tag(s_tag), .in_data(s_data),
      .out_valid(p_valid), .out_tag(p_tag), .out_data(p_data)
   );

   // tagged output stage keeps core and host responses on their own ports
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem_resp_data <= '0;
         mem_resp_valid <= 1'b0;
         host_rdata <= '0;
         host_rvalid <= 1'b0;
         err <= 1'b0;
      end else begin
         mem_resp_valid <= p_valid && p_tag == SRC_CORE;
         host_rvalid <= p_valid && p_tag == SRC_HOST;
         if (p_valid && p_tag == SRC_CORE) mem_resp_data <= p_data;
         if (p_valid && p_tag == SRC_HOST) host_rdata <= p_data[DATA_WIDTH-1:0];
         err <= err | new_err;
      end
endmodule

// File: tb/tb_scratchpad_responder.sv
// tb_scratchpad_responder: vector table plus scoreboard checks on a default instance,
// and hand sequences on a 4-lane, latency-3 instance.
module tb_scratchpad_responder;
   logic clk = 0, rst_n = 0;
   logic [12:0] mem_req_addr = '0, host_addr = '0;
   logic [31:0] mem_req_data = '0, host_wdata = '0, mem_resp_data, host_rdata;
   logic mem_read_en = 0, mem_write_en = 0, mem_resp_valid, host_req = 0, host_we = 0;
   logic host_gnt, host_rvalid, err;
   logic [12:0] a4 = '0, haddr4 = '0;
   logic [127:0] d4 = '0, rd4;
   logic [31:0] hwd4 = '0, hrd4;
   logic re4 = 0, we4 = 0, rv4, hreq4 = 0, hwe4 = 0, hg4, hrv4, err4;
   int n_chk = 0, n_fail = 0, cyc = 0, lat;

   typedef struct {logic [31:0] data; int due;} exp_t;
   typedef struct {bit wr; logic [12:0] addr; logic [31:0] data;} vec_t;
   exp_t cq[$], hq[$];
   exp_t ec, eh;
   vec_t vec[10];

   scratchpad_responder dut (
      .clk(clk), .rst_n(rst_n), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_resp_data(mem_resp_data),
      .mem_resp_valid(mem_resp_valid), .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid), .err(err));

   scratchpad_responder #(.BANKING_FACTOR(4), .DEPTH(16), .MEM_LATENCY(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .mem_req_addr(a4), .mem_req_data(d4),
      .mem_read_en(re4), .mem_write_en(we4), .mem_resp_data(rd4),
      .mem_resp_valid(rv4), .host_req(hreq4), .host_we(hwe4),
      .host_addr(haddr4), .host_wdata(hwd4), .host_gnt(hg4),
      .host_rdata(hrd4), .host_rvalid(hrv4), .err(err4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mem_resp_valid) begin
         if (cq.size() == 0) chk("core_resp_unexpected", mem_resp_valid, 0);
         else begin
            ec = cq.pop_front();
            chk("core_resp_data", mem_resp_data, ec.data);
            chk("core_resp_cycle", cyc, ec.due);
         end
      end else if (cq.size() > 0 && cq[0].due < cyc) begin
         ec = cq.pop_front();
         chk("core_resp_missing", mem_resp_valid, 1);
      end
      if (host_rvalid) begin
         if (hq.size() == 0) chk("host_resp_unexpected", host_rvalid, 0);
         else begin
            eh = hq.pop_front();
            chk("host_resp_data", host_rdata, eh.data);
            chk("host_resp_cycle", cyc, eh.due);
         end
      end else if (hq.size() > 0 && hq[0].due < cyc) begin
         eh = hq.pop_front();
         chk("host_resp_missing", host_rvalid, 1);
      end
   end

   task automatic core_rd(input logic [12:0] a, input logic [31:0] e);
      exp_t x;
      mem_read_en = 1; mem_write_en = 0; mem_req_addr = a;
      x.data = e; x.due = cyc + 2;
      cq.push_back(x);
      @(negedge clk);
   endtask

   task automatic core_wr(input logic [12:0] a, input logic [31:0] d);
      mem_read_en = 0; mem_write_en = 1; mem_req_addr = a; mem_req_data = d;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      mem_read_en = 0; mem_write_en = 0; host_req = 0;
      repeat (n) @(negedge clk);
   endtask

   task automatic host_wr(input logic [12:0] a, input logic [31:0] d);
      host_req = 1; host_we = 1; host_addr = a; host_wdata = d;
      #1 chk("host_wr_gnt", host_gnt, 1);
      @(negedge clk);
      host_req = 0;
   endtask

   task automatic host_rd(input logic [12:0] a, input logic [31:0] e);
      exp_t x;
      bit got = 0;
      host_req = 1; host_we = 0; host_addr = a;
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if (host_gnt) begin
            got = 1;
            x.data = e; x.due = cyc + 2;
            hq.push_back(x);
         end
         @(negedge clk);
      end
      chk("host_rd_granted", got, 1);
      host_req = 0;
   endtask

   task automatic rd4_chk(input string name, input logic [12:0] a, input logic [127:0] e);
      re4 = 1; a4 = a;
      @(negedge clk);
      re4 = 0; lat = 1;
      while (!rv4 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk(name, rd4, e);
      chk("bank_latency", lat, 3);
      @(negedge clk);
      chk("bank_valid_pulse", rv4, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d assertions, %0d failures", n_chk, n_fail);
      $fatal(1);
   end

   initial begin
      vec[0] = '{0, 13'h000, 32'h3F800000};
      vec[1] = '{0, 13'h004, 32'h40000000};
      vec[2] = '{1, 13'h040, 32'h12345678};
      vec[3] = '{0, 13'h040, 32'h12345678};
      vec[4] = '{1, 13'hFFC, 32'hA5A5A5A5};
      vec[5] = '{0, 13'hFFC, 32'hA5A5A5A5};
      vec[6] = '{1, 13'h080, 32'hDEADBEEF};
      vec[7] = '{1, 13'h084, 32'hCAFEF00D};
      vec[8] = '{0, 13'h084, 32'hCAFEF00D};
      vec[9] = '{0, 13'h080, 32'hDEADBEEF};
      repeat (2) @(negedge clk);
      chk("rst_resp_valid", mem_resp_valid, 0);
      chk("rst_host_rvalid", host_rvalid, 0);
      chk("rst_err", err, 0);
      rst_n = 1;
      @(negedge clk);
      host_wr(13'h0, 32'h3F800000);
      host_wr(13'h4, 32'h40000000);
      for (int i = 0; i < 10; i++)
         if (vec[i].wr) core_wr(vec[i].addr, vec[i].data);
         else core_rd(vec[i].addr, vec[i].data);
      idle(4);
      chk("table_drained", cq.size(), 0);
      chk("table_err_clear", err, 0);
      // host read waits out a stream of core reads
      host_req = 1; host_we = 0; host_addr = 13'h4;
      for (int i = 0; i < 4; i++) begin
         mem_read_en = 1; mem_req_addr = i[0] ? 13'h84 : 13'h80;
         cq.push_back('{i[0] ? 32'hCAFEF00D : 32'hDEADBEEF, cyc + 2});
         #1 chk("host_gnt_blocked", host_gnt, 0);
         @(negedge clk);
      end
      mem_read_en = 0;
      host_rd(13'h4, 32'h40000000);
      idle(3);
      chk("core_data_held", mem_resp_data, 32'hCAFEF00D);
      chk("host_rdata_held", host_rdata, 32'h40000000);
      core_rd(13'h2, 32'h0);
      idle(3);
      chk("err_misaligned", err, 1);
      core_rd(13'h0, 32'h3F800000);
      idle(3);
      // reset while a read is in flight: response must be dropped
      mem_read_en = 1; mem_req_addr = 13'h4;
      @(negedge clk);
      mem_read_en = 0; rst_n = 0;
      #1;
      chk("rst_mid_resp_data", mem_resp_data, 0);
      chk("rst_mid_host_rdata", host_rdata, 0);
      chk("rst_mid_err", err, 0);
      repeat (2) @(negedge clk);
      chk("rst_mid_no_valid", mem_resp_valid, 0);
      rst_n = 1;
      @(negedge clk);
      core_rd(13'h4, 32'h40000000);
      idle(3);
      // collision: write wins, read gets no response
      mem_read_en = 1; mem_write_en = 1; mem_req_addr = 13'h100; mem_req_data = 32'h11111111;
      host_req = 1; host_we = 0; host_addr = 13'h0;
      #1 chk("host_gnt_blocked_wr", host_gnt, 0);
      @(negedge clk);
      idle(3);
      chk("err_collision", err, 1);
      core_rd(13'h100, 32'h11111111);
      idle(3);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("err_cleared", err, 0);
      host_rd(13'h1000, 32'h0);
      idle(3);
      chk("err_host_range", err, 1);
      host_wr(13'h1000, 32'hFFFFFFFF);
      core_wr(13'h1000, 32'hEEEEEEEE);
      core_rd(13'h0, 32'h3F800000);
      idle(3);
      chk("final_drained", cq.size() + hq.size(), 0);
      // banked instance: four lanes per beat, latency 3
      for (int i = 0; i < 16; i++) begin
         hreq4 = 1; hwe4 = 1; haddr4 = 13'(i * 4); hwd4 = 32'h100 + 32'(i);
         @(negedge clk);
      end
      hreq4 = 0;
      rd4_chk("bank_read_top", 13'h30, {32'h10F, 32'h10E, 32'h10D, 32'h10C});
      chk("bank_err_clear", err4, 0);
      we4 = 1; a4 = 13'h10; d4 = {32'hD4, 32'hC4, 32'hB4, 32'hA4};
      @(negedge clk);
      we4 = 0;
      rd4_chk("bank_rd_after_wr", 13'h10, {32'hD4, 32'hC4, 32'hB4, 32'hA4});
      rd4_chk("bank_read_offset", 13'h0C, {32'hC4, 32'hB4, 32'hA4, 32'h103});
      chk("bank_err_still_clear", err4, 0);
      rd4_chk("bank_read_range", 13'h34, 128'h0);
      chk("bank_err_range", err4, 1);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("bank_err_reset", err4, 0);
      rd4_chk("bank_read_misaligned", 13'h2, 128'h0);
      chk("bank_err_misaligned", err4, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/scratchpad_responder.md
Name: scratchpad_responder

Overview:
- Memory-side responder for the systolic-wrapper memory interface: a fixed-latency, banked FP32 scratchpad that serves the wrapper's W/X beat reads and output beat writes.
- A second, lower-priority host port preloads operands and reads back results for DMA or the testbench.
- Sits between the systolic wrapper and the top-level memory map.

Parameters:
- DATA_WIDTH, 32, bits per word (FP32 bit pattern); must be a multiple of 8.
- BANKING_FACTOR, 1, words moved per core beat.
- ADDRESS_WIDTH, 13, byte-address width on both ports.
- DEPTH, 1024, words of storage.
- MEM_LATENCY, 2, initiator-visible read latency; must be >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req_addr  in  ADDRESS_WIDTH  core byte address of beat
- mem_req_data  in  BANKING_FACTOR*DATA_WIDTH  core write beat; word b at [b*DATA_WIDTH +: DATA_WIDTH]
- mem_read_en  in  1  core read request
- mem_write_en  in  1  core write request
- mem_resp_data  out  BANKING_FACTOR*DATA_WIDTH  core read beat
- mem_resp_valid  out  1  one-cycle pulse when mem_resp_data updates
- host_req  in  1  host single-word request
- host_we  in  1  host write (1) / read (0)
- host_addr  in  ADDRESS_WIDTH  host byte address
- host_wdata  in  DATA_WIDTH  host write word
- host_gnt  out  1  host request accepted this cycle
- host_rdata  out  DATA_WIDTH  host read word
- host_rvalid  out  1  one-cycle pulse when host_rdata updates
- err  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: mem_resp_data=0, mem_resp_valid=0, host_rdata=0, host_rvalid=0, err=0, latency pipeline emptied.
- Storage contents are not reset. Reset mid-operation drops all in-flight reads, with no response pulse.
- Address decode:
  - BPW = DATA_WIDTH/8.
  - word index = addr / BPW.
  - Core beat covers words idx..idx+BANKING_FACTOR-1; word b maps to bank lane b.
  - No wrap-around.
- Error conditions (each sets err, which stays set until reset):
  - addr not a multiple of BPW (misaligned).
  - idx+BANKING_FACTOR > DEPTH on the core port, or idx >= DEPTH on the host port (out of range).
  - mem_read_en and mem_write_en both high in the same cycle.
- Core write: sampled at edge k. All lanes are written at edge k and are visible to a read sampled at edge k+1. Misaligned or out-of-range writes are dropped.
- Core read: sampled at edge k.
  - mem_resp_data is registered at edge k+MEM_LATENCY-1 and held until the next core read response.
  - mem_resp_valid is high for exactly that one cycle.
  - Out-of-range or misaligned reads return all-zero data, still with a valid pulse.
- Read/write collision: if read and write are asserted together, the write executes and the read is ignored (no response).
- Throughput: back-to-back core reads are accepted one per cycle, fully pipelined. Response order equals request order.
- Host arbitration:
  - host_gnt = host_req & ~mem_read_en & ~mem_write_en (combinational). The core port always wins.
  - A granted host read returns host_rdata with a host_rvalid pulse MEM_LATENCY-1 cycles after the grant edge.
  - Pipeline entries carry a source tag, so core and host responses never overwrite each other's outputs.
  - The host holds host_req until host_gnt is seen.
- Read-during-write on the same word at the same edge cannot occur: core read and core write are mutually exclusive, and the host only gets the array when the core port is idle.

Decomposition:
- Package tpu_mem_pkg: BPW localparam function, src_t enum {SRC_CORE, SRC_HOST}, and error-cause helper function.
- Sub-module mem_latency_pipe: parameterised valid/tag/data delay line of depth MEM_LATENCY-2, placed after the registered array read. Depth 0 degenerates to a wire.

Test Plan:
- Host writes 0x3F800000 (1.0) at byte 0x0 and 0x40000000 (2.0) at 0x4, then core reads 0x0 with BANKING_FACTOR=1 → first core read returns 0x3F800000, second returns 0x40000000; each mem_resp_valid pulse lands exactly 1 cycle after its sampling edge (MEM_LATENCY=2).
- Run the systolic wrapper against this block: N=4 W=identity, X=[1..16] → stored output region equals X bit-exact; done_store asserted.
- Core write at 0x40 then core read of 0x40 on the next cycle → read returns the newly written value.
- Host read requested while core reads are streaming → host_gnt=0 until core idle; host_rvalid follows 1 cycle after grant with the correct word; core data is unaffected.
- BANKING_FACTOR=4, DEPTH=16: core read at 0x30 → lanes = words 12..15, err=0. Core read at 0x34 → data 0, err=1. Misaligned 0x2 also sets err.
- Assert rst_n low one cycle after a core read is sampled → no mem_resp_valid pulse. All outputs 0 during reset; previously written contents remain readable after release.
